// File: rtl/scrambler_pkg.sv
// ----------------------------------------------------------------------------
// scrambler_pkg
// Shared definitions for the primary scrambler LFSR control path: seed width,
// LFSR register-word addresses, register data width, sequencer state encoding
// and a helper that slices the zero-extended seed into 32-bit register words.
// ----------------------------------------------------------------------------
package scrambler_pkg;

    localparam int POLY_WIDTH = 86;
    localparam int REG_W      = 32;
    // Seed is staged zero-extended to three full register words.
    localparam int SEED_EXT_W = 3 * REG_W;

    localparam logic [11:0] LFSR_ADDR0 = 12'h0d4;
    localparam logic [11:0] LFSR_ADDR1 = 12'h0d5;
    localparam logic [11:0] LFSR_ADDR2 = 12'h0d6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD0  = 3'd1,
        ST_LD1  = 3'd2,
        ST_LD2  = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Select register word idx (0 = least significant) of the extended seed.
    function automatic logic [REG_W-1:0] seed_word(input logic [SEED_EXT_W-1:0] seed_ext,
                                                   input logic [1:0]            idx);
        logic [REG_W-1:0] w;
        case (idx)
            2'd0:    w = seed_ext[REG_W-1:0];
            2'd1:    w = seed_ext[2*REG_W-1:REG_W];
            2'd2:    w = seed_ext[3*REG_W-1:2*REG_W];
            default: w = {REG_W{1'b0}};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/scrambler_seed_ctrl.sv
// ----------------------------------------------------------------------------
// scrambler_seed_ctrl
// Control sequencer for the 86-bit primary scrambler LFSR. Accepts a
// seed + frame-length request, writes the seed into the LFSR as three 32-bit
// register writes (BASE_ADDR, +1, +2), then advances the LFSR once per
// consumed upstream data word until the frame length is used up, and pulses
// frame_done. abort returns to IDLE from any busy state without further
// writes or frame_done.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   seed_valid/ready    request handshake; seed, frame_words captured on accept
//   abort               synchronous cancel
//   dat_valid/ready     upstream data word handshake (ready only in RUN)
//   lfsr_write/addr/    LFSR register-write port
//   lfsr_wdata
//   lfsr_enable         LFSR advance strobe (Mealy on dat_valid/abort)
//   busy                sequencer not idle
//   frame_done          one-cycle completion pulse
// ----------------------------------------------------------------------------
module scrambler_seed_ctrl #(
    parameter int          POLY_WIDTH = scrambler_pkg::POLY_WIDTH,
    parameter logic [11:0] BASE_ADDR  = scrambler_pkg::LFSR_ADDR0,
    parameter int          CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [POLY_WIDTH-1:0] seed,
    input  logic [CNT_W-1:0]      frame_words,
    input  logic                  abort,
    input  logic                  dat_valid,
    output logic                  dat_ready,
    output logic                  lfsr_write,
    output logic [11:0]           lfsr_addr,
    output logic [31:0]           lfsr_wdata,
    output logic                  lfsr_enable,
    output logic                  busy,
    output logic                  frame_done
);

    import scrambler_pkg::*;

    state_e                  state_q, state_d;
    logic [POLY_WIDTH-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEED_EXT_W-1:0]   seed_ext_s;

    logic                    seed_ready_s;
    logic                    dat_ready_s;
    logic                    enable_s;
    logic                    write_s;
    logic [11:0]             addr_s;
    logic [REG_W-1:0]        wdata_s;
    logic                    done_s;

    // Zero-extend the captured seed so the top word carries seed[POLY_WIDTH-1:64].
    always_comb begin
        seed_ext_s                 = {SEED_EXT_W{1'b0}};
        seed_ext_s[POLY_WIDTH-1:0] = seed_q;
    end

    // State, seed and frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seed_q  <= {POLY_WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; LD/DONE outputs depend on state only,
    // the RUN advance strobe follows dat_valid/abort in the same cycle.
    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        cnt_d        = cnt_q;
        seed_ready_s = 1'b0;
        dat_ready_s  = 1'b0;
        enable_s     = 1'b0;
        write_s      = 1'b0;
        addr_s       = 12'h000;
        wdata_s      = {REG_W{1'b0}};
        done_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                seed_ready_s = ~abort;
                if (seed_valid && !abort) begin
                    seed_d  = seed;
                    cnt_d   = frame_words;
                    state_d = ST_LD0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LD0: begin
                write_s = 1'b1;
                addr_s  = BASE_ADDR;
                wdata_s = seed_word(seed_ext_s, 2'd0);
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LD1;
                end
            end

            ST_LD1: begin
                write_s = 1'b1;
                addr_s  = BASE_ADDR + 12'd1;
                wdata_s = seed_word(seed_ext_s, 2'd1);
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LD2;
                end
            end

            ST_LD2: begin
                write_s = 1'b1;
                addr_s  = BASE_ADDR + 12'd2;
                wdata_s = seed_word(seed_ext_s, 2'd2);
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    // Load-only request skips RUN entirely.
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                dat_ready_s = 1'b1;
                enable_s    = dat_valid & ~abort;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dat_valid) begin
                    // RUN is only entered with a non-zero count, so no wrap.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign seed_ready  = seed_ready_s;
    assign dat_ready   = dat_ready_s;
    assign lfsr_enable = enable_s;
    assign lfsr_write  = write_s;
    assign lfsr_addr   = addr_s;
    assign lfsr_wdata  = wdata_s;
    assign frame_done  = done_s;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scrambler_seed_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for scrambler_seed_ctrl. A cycle-count model (cycles
// since accept, words remaining) predicts every output on every cycle;
// directed scenarios pin the model with literal expectations, then random
// traffic exercises stalls, aborts and back-to-back frames.
// ----------------------------------------------------------------------------
module tb_scrambler_seed_ctrl;

    localparam int PW = 86;
    localparam int CW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          seed_valid = 1'b0;
    logic          seed_ready;
    logic [PW-1:0] seed = '0;
    logic [CW-1:0] frame_words = '0;
    logic          abort = 1'b0;
    logic          dat_valid = 1'b0;
    logic          dat_ready;
    logic          lfsr_write;
    logic [11:0]   lfsr_addr;
    logic [31:0]   lfsr_wdata;
    logic          lfsr_enable;
    logic          busy;
    logic          frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int frames_seen = 0;

    always #5 clk = ~clk;

    scrambler_seed_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed_valid  (seed_valid),
        .seed_ready  (seed_ready),
        .seed        (seed),
        .frame_words (frame_words),
        .abort       (abort),
        .dat_valid   (dat_valid),
        .dat_ready   (dat_ready),
        .lfsr_write  (lfsr_write),
        .lfsr_addr   (lfsr_addr),
        .lfsr_wdata  (lfsr_wdata),
        .lfsr_enable (lfsr_enable),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Behavioural model: m_k counts cycles since the accepting edge
    // (1..3 = the three seed writes, 4 = consuming words), m_rem words left,
    // m_done marks the completion cycle.
    bit            m_busy;
    int            m_k;
    int            m_rem;
    bit            m_done;
    logic [PW-1:0] m_seed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_rem  <= 0;
            m_done <= 1'b0;
            m_seed <= '0;
        end else if (!m_busy) begin
            if (seed_valid && !abort) begin
                m_busy <= 1'b1;
                m_k    <= 1;
                m_rem  <= int'(frame_words);
                m_seed <= seed;
                m_done <= 1'b0;
            end
        end else if (abort || m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_k <= 3) begin
            m_k <= m_k + 1;
            if (m_k == 3 && m_rem == 0) m_done <= 1'b1;
        end else if (dat_valid) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) m_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic        e_wr, e_run;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        logic [49:0] e_vec, a_vec;
        e_wr   = m_busy && !m_done && (m_k <= 3);
        e_run  = m_busy && !m_done && (m_k > 3);
        e_addr = 12'h000;
        e_data = 32'h0;
        if (e_wr) begin
            e_addr = 12'h0d4 + 12'(m_k - 1);
            case (m_k)
                1:       e_data = m_seed[31:0];
                2:       e_data = m_seed[63:32];
                default: e_data = {10'd0, m_seed[85:64]};
            endcase
        end
        e_vec = {!m_busy && !abort, m_busy, m_busy && m_done, e_run,
                 e_run && dat_valid && !abort, e_wr, e_addr, e_data};
        a_vec = {seed_ready, busy, frame_done, dat_ready, lfsr_enable,
                 lfsr_write, lfsr_addr, lfsr_wdata};
        if (frame_done) frames_seen++;
        chk("cycle_outputs", 64'(a_vec), 64'(e_vec));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current (idle) cycle; returns in cycle T+1.
    task automatic start(input logic [PW-1:0] s, input logic [CW-1:0] fw);
        seed_valid  = 1'b1;
        seed        = s;
        frame_words = fw;
        step();
        seed_valid  = 1'b0;
    endtask

    function automatic logic [PW-1:0] rand_seed();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    initial begin
        logic [4:0] pat;
        logic [PW-1:0] s;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Seed load, frame_words = 0.
        start({22'h1ABCDE, 32'hDEADBEEF, 32'hCAFEF00D}, 16'd0);
        @(negedge clk); chk("ld_word0", {19'd0, lfsr_write, lfsr_addr, lfsr_wdata}, {19'd0, 1'b1, 12'h0d4, 32'hCAFEF00D});
        step(); @(negedge clk); chk("ld_word1", {19'd0, lfsr_write, lfsr_addr, lfsr_wdata}, {19'd0, 1'b1, 12'h0d5, 32'hDEADBEEF});
        step(); @(negedge clk); chk("ld_word2", {19'd0, lfsr_write, lfsr_addr, lfsr_wdata}, {19'd0, 1'b1, 12'h0d6, 32'h001ABCDE});
        step(); @(negedge clk); chk("ld_only_done", {62'd0, frame_done, lfsr_enable}, 64'd2);
        step(); @(negedge clk); chk("ld_only_idle", {62'd0, seed_ready, busy}, 64'd2);

        // Continuous frame of 4 words.
        dat_valid = 1'b1;
        start(rand_seed(), 16'd4);
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("cont_enable", {63'd0, lfsr_enable}, 64'd1);
            step();
        end
        @(negedge clk); chk("cont_done", {62'd0, frame_done, lfsr_enable}, 64'd2);
        step(); @(negedge clk); chk("cont_idle", {62'd0, seed_ready, busy}, 64'd2);
        dat_valid = 1'b0;

        // Stalled frame of 3 words, dat_valid 1,0,1,0,1 from T+4.
        start(rand_seed(), 16'd3);
        repeat (3) step();
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            dat_valid = pat[i];
            @(negedge clk); chk("stall_enable", {63'd0, lfsr_enable}, {63'd0, pat[i]});
            step();
        end
        dat_valid = 1'b0;
        @(negedge clk); chk("stall_done", {63'd0, frame_done}, 64'd1);
        step();

        // Abort in LD1: no third write, no frame_done.
        start(rand_seed(), 16'd5);
        step();
        abort = 1'b1;
        @(negedge clk); chk("abort_ld1_write", {51'd0, lfsr_write, lfsr_addr}, {51'd0, 1'b1, 12'h0d5});
        step();
        abort = 1'b0;
        @(negedge clk); chk("abort_idle", {62'd0, busy, lfsr_write}, 64'd0);
        step(); @(negedge clk); chk("abort_no_done", {62'd0, busy, frame_done}, 64'd0);

        // abort with seed_valid in IDLE blocks acceptance.
        step();
        seed_valid = 1'b1; abort = 1'b1;
        @(negedge clk); chk("abort_blocks_ready", {63'd0, seed_ready}, 64'd0);
        step();
        seed_valid = 1'b0; abort = 1'b0;
        @(negedge clk); chk("abort_no_accept", {63'd0, busy}, 64'd0);
        step();

        // Asynchronous reset in the middle of a 10-word frame.
        dat_valid = 1'b1;
        start(rand_seed(), 16'd10);
        repeat (4) step();
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs",
               {14'd0, seed_ready, busy, frame_done, dat_ready, lfsr_enable, lfsr_write, lfsr_addr, lfsr_wdata},
               {14'd0, 1'b1, 5'b00000, 12'h000, 32'h0});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        s = rand_seed();
        start(s, 16'd2);
        @(negedge clk); chk("reload_word0", {19'd0, lfsr_write, lfsr_addr, lfsr_wdata}, {19'd0, 1'b1, 12'h0d4, s[31:0]});
        repeat (7) step();
        dat_valid = 1'b0;

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            seed_valid  = ($urandom_range(0, 3) == 0);
            seed        = rand_seed();
            frame_words = ($urandom_range(0, 15) == 0) ? 16'd1 : 16'($urandom_range(0, 9));
            dat_valid   = ($urandom_range(0, 3) != 0);
            abort       = ($urandom_range(0, 49) == 0);
            step();
        end
        seed_valid = 1'b0; abort = 1'b0; dat_valid = 1'b1;
        repeat (20) step();
        chk("frames_completed", {63'd0, frames_seen > 20}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scrambler_seed_ctrl.md
# scrambler_seed_ctrl

Sequencer that owns the control side of the 86-bit primary scrambler LFSR. It accepts a seed-plus-frame-length request and writes the seed into the LFSR through its 32-bit register-write port as three consecutive word writes. It then gates the LFSR `enable` once per accepted upstream data word until the frame length is exhausted. It sits between the frame/packet front end and the LFSR datapath, and replaces the host-driven seed writes on the scrambling path.

## Interface
- `POLY_WIDTH`, 86: LFSR/seed width. Legal range 65–96.
- `BASE_ADDR`, 12'h0d4: LFSR word-0 address. Word 1 is at `BASE_ADDR+1`; word 2 is at `BASE_ADDR+2`.
- `CNT_W`, 16: frame-length counter width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `seed_valid`  in  1  request present.
- `seed_ready`  out  1  request accepted when `seed_valid & seed_ready`.
- `seed`  in  POLY_WIDTH  LFSR seed, captured on accept.
- `frame_words`  in  CNT_W  number of LFSR advances (data words) in the frame, captured on accept. 0 means load only.
- `abort`  in  1  synchronous cancel.
- `dat_valid`  in  1  upstream data word present.
- `dat_ready`  out  1  controller consuming words.
- `lfsr_write`  out  1  LFSR register-write strobe.
- `lfsr_addr`  out  12  LFSR register address.
- `lfsr_wdata`  out  32  LFSR register write data.
- `lfsr_enable`  out  1  LFSR advance, one multi-step advance per cycle high.
- `busy`  out  1  not IDLE.
- `frame_done`  out  1  single-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, LD0, LD1, LD2, RUN, DONE. State, captured seed and word counter are registers.
- IDLE:
  - `seed_ready = ~abort`.
  - On accept, capture `seed` and `frame_words`, then go to LD0.
- LD0: `lfsr_write=1`, `lfsr_addr=BASE_ADDR`, `lfsr_wdata=seed[31:0]`. Next state LD1.
- LD1: `lfsr_write=1`, `lfsr_addr=BASE_ADDR+1`, `lfsr_wdata=seed[63:32]`. Next state LD2.
- LD2: `lfsr_write=1`, `lfsr_addr=BASE_ADDR+2`, `lfsr_wdata` = `seed[POLY_WIDTH-1:64]` zero-extended to 32 bits. Next state is DONE if the count is 0, else RUN.
- RUN:
  - `dat_ready=1`.
  - `lfsr_enable = dat_valid & ~abort`.
  - Each cycle with `lfsr_enable` high decrements the counter. An enabled cycle with count==1 goes to DONE.
  - Cycles with `dat_valid=0` hold state; the LFSR does not advance.
- DONE: `frame_done=1` for one cycle, then go to IDLE.
- Outside the LD states: `lfsr_write=0`, `lfsr_addr=0`, `lfsr_wdata=0`.
- `lfsr_enable` and `lfsr_write` are never high in the same cycle.
- `abort` in any non-IDLE state: next state is IDLE.
  - No further writes and no `frame_done`.
  - A partially loaded LFSR is left as is.
- `abort` in IDLE blocks acceptance that cycle.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst_n` low, asynchronous) puts the FSM in IDLE and clears seed and counter.
- Output values while in reset: `seed_ready=1`, `busy=0`, `frame_done=0`, `dat_ready=0`, `lfsr_enable=0`, `lfsr_write=0`, `lfsr_addr=0`, `lfsr_wdata=0`.
- Reset deassertion: first accept possible on the first clock edge after release.
- Outputs in LD/DONE states are Moore (state decode only).
- `lfsr_enable` is Mealy on `dat_valid`/`abort`, so the LFSR advances on the same edge the word is consumed.
- Accept at edge T gives this sequence:
  - Writes in cycles T+1, T+2, T+3.
  - RUN from T+4.
  - With continuous `dat_valid`, the last enable is at cycle T+3+`frame_words`.
  - `frame_done` in the next cycle.
  - IDLE, with `seed_ready` high, in the cycle after that.
- `frame_words=0`: DONE in cycle T+4, no enable.
- Back-to-back frames: minimum gap is 1 IDLE cycle. A new accept is allowed in the first IDLE cycle.
- Counter never wraps. Decrement occurs only when count ≥1 in RUN. A captured 0 bypasses RUN.
- `frame_words` max = 2^CNT_W−1.
- `seed_valid` during non-IDLE states is ignored (`seed_ready=0`). The request must be held until accepted.

## Structure
- Shared package `scrambler_pkg` holds:
  - the state enum;
  - `POLY_WIDTH`;
  - the LFSR word addresses 12'h0d4/0d5/0d6;
  - the register data width of 32.
- Single module with no sub-module. The counter and seed register are inline.
- Outputs connect directly to the LFSR's `write`/`addr`/`lfsrdin`/`enable`.

## Test plan
- Seed load:
  - Stimulus: reset, then accept with `seed[85:64]=22'h1ABCDE`, `seed[63:32]=32'hDEADBEEF`, `seed[31:0]=32'hCAFEF00D`, `frame_words=0`.
  - Response: writes 0x0d4/0xCAFEF00D, 0x0d5/0xDEADBEEF, 0x0d6/0x001ABCDE in cycles T+1..T+3, `frame_done` at T+4, no `lfsr_enable`.
- Continuous frame:
  - Stimulus: `frame_words=4`, `dat_valid` held 1.
  - Response: `lfsr_enable` high T+4..T+7, `frame_done` at T+8, `seed_ready` high at T+9. LFSR state equals the seed advanced 4×.
- Stalled frame:
  - Stimulus: `frame_words=3`, `dat_valid` pattern 1,0,1,0,1 from T+4.
  - Response: enable only at T+4, T+6, T+8, `frame_done` at T+9.
- Abort mid-load:
  - Stimulus: `abort` asserted in LD1.
  - Response: no 0x0d6 write, IDLE next cycle, no `frame_done`.
  - Stimulus: `abort` together with `seed_valid` in IDLE.
  - Response: no accept.
- Reset mid-RUN:
  - Stimulus: `rst_n` low asynchronously at T+5 of a 10-word frame.
  - Response: all outputs reach reset values without waiting for a clock edge. After release, a new request is accepted and reloads cleanly.
